// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds (or subtracts) two WIDTH-bit operands DIGIT bits
// per clock, least-significant digit first, with a ready/busy/done handshake.
//
// Parameters:
//   WIDTH  operand/result width in bits (multiple of DIGIT)
//   DIGIT  bits processed per RUN cycle; NDIG = WIDTH/DIGIT cycles per result
// Ports:
//   CLK    rising-edge clock
//   RST    asynchronous active-high reset
//   START  operation request, accepted while READY=1
//   A, B   operands;  Cin  carry-in;  SUB  subtract select
//   READY  a START will be accepted;  BUSY  digits in flight
//   DONE   one-cycle pulse with a valid result
//   S      sum/difference;  Cout  carry out of MSB;  OVF  signed overflow
// Build option:
//   DIGIT_SERIAL_ADDER_SUB_EN  enables subtraction (SUB=1 -> S = A - B).
//   Without it SUB is ignored and the block is a pure adder.
module digit_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             SUB,
    output logic             READY,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OVF
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    if ((WIDTH % DIGIT) != 0 || DIGIT == 0) begin : g_bad_param
        $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
    end

    logic [1:0]       state, state_nxt;
    logic             ready_nxt, busy_nxt, done_nxt;
    logic             accept;
    logic             last;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] s_nxt;

    // Operand conditioning at accept time: B' and the carry into digit 0.
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    always_comb begin
        b_in = SUB ? ~B : B;
        c_in = SUB ? 1'b1 : Cin;
    end
`else
    logic unused_sub;
    assign unused_sub = SUB;

    always_comb begin
        b_in = B;
        c_in = Cin;
    end
`endif

    // Next-state, handshake decode and the current digit's adder.
    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        a_dig     = '0;
        b_dig     = '0;
        s_nxt     = S;

        for (int i = 0; i < int'(NDIG); i++) begin
            if (k == KW'(i)) begin
                a_dig = a_q[i*DIGIT +: DIGIT];
                b_dig = b_q[i*DIGIT +: DIGIT];
            end
        end
        dsum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
        for (int i = 0; i < int'(NDIG); i++) begin
            if (k == KW'(i)) begin
                s_nxt[i*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
            end
        end
        last = (k == KW'(NDIG - 1));

        case (state)
            IDLE: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        ready_nxt = (state_nxt != RUN);
        busy_nxt  = (state_nxt == RUN);
        done_nxt  = (state_nxt == FIN);
    end

    // State register with registered handshake outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            READY <= 1'b1;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_nxt;
            READY <= ready_nxt;
            BUSY  <= busy_nxt;
            DONE  <= done_nxt;
        end
    end

    // Datapath: latch operands on accept, then one digit per RUN cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            k     <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            OVF   <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= b_in;
            carry <= c_in;
            k     <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            OVF   <= 1'b0;
        end else if (state == RUN) begin
            S     <= s_nxt;
            carry <= dsum[DIGIT];
            k     <= k + KW'(1);
            if (last) begin
                Cout <= dsum[DIGIT];
                // dsum[DIGIT-1] is the new result MSB on the final digit.
                OVF  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (dsum[DIGIT-1] != a_q[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Testbench for digit_serial_adder: scoreboard of expected results pushed on
// each accepting edge and popped on each DONE pulse, plus targeted checks of
// latency, handshake, back-to-back starts, reset abort and DIGIT=WIDTH.
module tb_digit_serial_adder;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, start2;
    logic [15:0] a, b;
    logic        cin, sub;
    logic        ready, busy, done, cout, ovf;
    logic [15:0] s;
    logic        ready2, busy2, done2, cout2, ovf2;
    logic [15:0] s2;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .CLK(clk), .RST(rst), .START(start), .A(a), .B(b), .Cin(cin), .SUB(sub),
        .READY(ready), .BUSY(busy), .DONE(done), .S(s), .Cout(cout), .OVF(ovf)
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
        .CLK(clk), .RST(rst), .START(start2), .A(a), .B(b), .Cin(cin), .SUB(sub),
        .READY(ready2), .BUSY(busy2), .DONE(done2), .S(s2), .Cout(cout2), .OVF(ovf2)
    );

    int total = 0;
    int bad   = 0;

    logic [17:0] sbq[$];
    logic [17:0] sbq16[$];
    logic [17:0] e1, e2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: {cout, ovf, s}.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic su);
        logic [15:0] yp;
        logic        c0;
        logic [16:0] r;
        yp = y;
        c0 = ci;
        if (SUB_EN && su) begin
            yp = ~y;
            c0 = 1'b1;
        end
        r = {1'b0, x} + {1'b0, yp} + 17'(c0);
        return {r[16], (x[15] == yp[15]) && (r[15] != x[15]), r[15:0]};
    endfunction

    // Scoreboard monitors.
    always @(negedge clk) begin
        if (done) begin
            check("sb_pending", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e1 = sbq.pop_front();
                check("sb_s",    32'(s),    32'(e1[15:0]));
                check("sb_cout", 32'(cout), 32'(e1[17]));
                check("sb_ovf",  32'(ovf),  32'(e1[16]));
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            check("sb16_pending", 32'(sbq16.size() != 0), 32'd1);
            if (sbq16.size() != 0) begin
                e2 = sbq16.pop_front();
                check("sb16_s",    32'(s2),    32'(e2[15:0]));
                check("sb16_cout", 32'(cout2), 32'(e2[17]));
                check("sb16_ovf",  32'(ovf2),  32'(e2[16]));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(ready), 32'd1);
    endtask

    // Called at a negedge; returns at the first negedge after the accept edge
    // with inputs scrambled so later changes cannot leak into the result.
    task automatic issue(input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic su);
        wait_ready();
        a = x; b = y; cin = ci; sub = su;
        start = 1'b1;
        @(posedge clk);
        sbq.push_back(model(x, y, ci, su));
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
    endtask

    // n counts negedges from the one after the accept edge to the DONE one.
    task automatic wait_done(output int n, output int nb);
        n  = 1;
        nb = 0;
        while (!done && n < 50) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        check("done_wait", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, nb;
        logic seen;
        logic [15:0] ra, rb;

        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_s",     32'(s),     32'd0);
        check("rst_cout",  32'(cout),  32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic add, latency and BUSY duration.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(n, nb);
        check("add_latency", 32'(n),  32'd5);
        check("add_busy",    32'(nb), 32'd4);
        check("add_s",       32'(s),  32'h5555);
        check("add_cout",    32'(cout), 32'd0);
        check("add_ovf",     32'(ovf),  32'd0);
        repeat (2) @(negedge clk);
        check("hold_s",     32'(s),     32'h5555);
        check("hold_ready", 32'(ready), 32'd1);
        check("hold_busy",  32'(busy),  32'd0);

        // Carry ripple and signed overflow.
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(n, nb);
        check("ripple_s",    32'(s),    32'h0000);
        check("ripple_cout", 32'(cout), 32'd1);
        check("ripple_ovf",  32'(ovf),  32'd0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(n, nb);
        check("ovf_s",   32'(s),   32'h8000);
        check("ovf_ovf", 32'(ovf), 32'd1);
        issue(16'h00FF, 16'h0F00, 1'b1, 1'b0);
        wait_done(n, nb);
        check("cin_s", 32'(s), 32'h1000);

        // Subtract (or ignored SUB in an adder-only build).
        issue(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_done(n, nb);
        check("sub_s",    32'(s),    SUB_EN ? 32'hFFFE : 32'h000C);
        check("sub_cout", 32'(cout), 32'd0);
        issue(16'h0009, 16'h0003, 1'b0, 1'b1);
        wait_done(n, nb);

        // START during RUN with other operands is ignored.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, nb);
        check("ignore_s", 32'(s), 32'h3333);

        // START held through FIN: back-to-back with no IDLE cycle.
        @(negedge clk);
        wait_ready();
        a = 16'h0100; b = 16'h0200; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        sbq.push_back(model(16'h0100, 16'h0200, 1'b0, 1'b0));
        @(negedge clk);
        a = 16'h0A0A; b = 16'h0505;
        wait_done(n, nb);
        check("b2b_first_s", 32'(s), 32'h0300);
        @(posedge clk);
        sbq.push_back(model(16'h0A0A, 16'h0505, 1'b0, 1'b0));
        @(negedge clk);
        check("b2b_busy",  32'(busy),  32'd1);
        check("b2b_ready", 32'(ready), 32'd0);
        start = 1'b0;
        wait_done(n, nb);
        check("b2b_second_s", 32'(s), 32'h0F0F);

        // Reset after the second RUN edge aborts with no DONE.
        @(negedge clk);
        issue(16'h0123, 16'h0456, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        sbq.delete();
        check("abort_s",     32'(s),     32'd0);
        check("abort_cout",  32'(cout),  32'd0);
        check("abort_ovf",   32'(ovf),   32'd0);
        check("abort_done",  32'(done),  32'd0);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | done;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        issue(16'hABCD, 16'h1111, 1'b1, 1'b0);
        wait_done(n, nb);
        check("post_abort_s", 32'(s), 32'hBCDF);

        // Single-digit instance: one RUN cycle.
        @(negedge clk);
        a = 16'h8000; b = 16'h8000; cin = 1'b0; sub = 1'b0;
        check("d16_ready", 32'(ready2), 32'd1);
        start2 = 1'b1;
        @(posedge clk);
        sbq16.push_back(model(16'h8000, 16'h8000, 1'b0, 1'b0));
        @(negedge clk);
        start2 = 1'b0;
        check("d16_busy", 32'(busy2), 32'd1);
        n = 1;
        while (!done2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("d16_latency", 32'(n),     32'd2);
        check("d16_s",       32'(s2),    32'h0000);
        check("d16_cout",    32'(cout2), 32'd1);
        check("d16_ovf",     32'(ovf2),  32'd1);

        // Random operations checked by the scoreboard.
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            issue(ra, rb, 1'($urandom), 1'($urandom));
            wait_done(n, nb);
            check("rnd_latency", 32'(n), 32'd5);
        end

        repeat (3) @(negedge clk);
        check("sb_drain",   32'(sbq.size()),   32'd0);
        check("sb16_drain", 32'(sbq16.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
